fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controls the instruction-fetch stage. It owns the fetch PC, issues one instruction-memory request at a time, and checks each PC for misalignment and range before it is sent. It presents each fetched word to the IF/ID pipeline register through a valid/ready handshake. It handles decode back-pressure, redirects (branch/jump/flush) and fetch faults.

Parameters:
XLEN, 64, width of PC and addresses
RESET_PC, 64'h0, first PC fetched after reset
IMEM_WORDS, 1024, number of 32-bit words in instruction memory; valid iff PC[1:0]==0 and PC[XLEN-1:2] < IMEM_WORDS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  level; 0 blocks new requests, an outstanding one still completes
redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  XLEN  new fetch PC
imem_req  out  1  request strobe, one cycle per request, combinational from state
imem_addr  out  XLEN  = req_pc (registered)
imem_rvalid  in  1  response for the outstanding request, latency >= 1 cycle
imem_rdata  in  32  instruction word
imem_err  in  1  qualified by imem_rvalid; bus error
if_valid  out  1  output slot holds an entry
if_ready  in  1  IF/ID accepts the entry this cycle
if_pc  out  XLEN  PC of entry
if_instr  out  32  instruction of entry
if_fault  out  1  entry is a fault marker

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_pc=RESET_PC, outstanding=0, discard=0, if_valid=0, if_pc=0, if_instr=0, if_fault=0; imem_req=0.
- States: IDLE, RUN, FAULT. IDLE->RUN on the first edge with fetch_en=1. RUN->FAULT when a fault entry is written. FAULT->RUN on redirect_valid. In any state, redirect_valid forces RUN.
- Credit rule: exactly one credit covers the in-flight request plus the output slot. Define issue_ok = state==RUN && fetch_en && !redirect_valid && !outstanding && (!if_valid || if_ready).
- With issue_ok and a valid req_pc: imem_req=1 and outstanding<=1.
- With issue_ok and an invalid req_pc: imem_req=0. Write a fault entry (if_valid=1, if_fault=1, if_pc=req_pc, if_instr=32'h00000013). Go to FAULT.
- Response (imem_rvalid && !discard): outstanding<=0 and the slot is written at that edge. The slot holds if_pc=req_pc and if_instr=imem_rdata. If imem_err=1, it holds if_fault=1, if_instr=32'h00000013, state->FAULT. Otherwise if_fault=0 and req_pc<=req_pc+4 (mod 2^XLEN).
- Slot timing: if_valid rises the cycle after imem_rvalid. The slot is always empty when a response arrives, guaranteed by the credit rule.
- Handshake: the entry retires on if_valid && if_ready. if_pc, if_instr and if_fault stay stable while if_valid && !if_ready.
- Throughput: memory latency L gives one instruction per L+1 cycles with if_ready held at 1.
- Redirect (edge with redirect_valid=1): req_pc<=redirect_pc and if_valid<=0, regardless of if_ready.
- Redirect with an outstanding request: if imem_rvalid is also high that cycle, the response is dropped and outstanding<=0. Otherwise discard<=1.
- Discard: a response arriving with discard=1 is dropped; discard<=0 and outstanding<=0.
- Redirect has priority over a same-cycle response, fault or issue. Back-to-back redirects: the last one wins.
- Faulted redirect target: a redirect to an invalid PC faults on the next issue_ok. No memory request is made.
- fetch_en=0 in RUN: no issue; the outstanding response and slot drain normally.
- A response is never expected with outstanding=0; if one arrives it is ignored.

Optional Feature:
FETCH_PERF_EN: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping.
- perf_fetch_cnt increments on each non-fault retire.
- perf_stall_cnt increments on each cycle with if_valid && !if_ready.
Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds: the state enum (IDLE/RUN/FAULT), the NOP constant 32'h00000013, the XLEN default, and an addr_valid function (alignment plus range check against IMEM_WORDS).
- One natural sub-module, fetch_out_slot: a single-entry output register with the valid/ready and flush logic.

Test Plan:
- Reset release, fetch_en=1, memory latency 1, if_ready=1 -> imem_req with imem_addr 0x0, 0x4, 0x8 on every second cycle; if_valid entries pc=0x0/0x4/0x8 carrying the memory data.
- if_ready=0 for 5 cycles holding entry pc=0x4 -> if_pc, if_instr and if_valid stable; no imem_req; fetch resumes at 0x8 after the accept.
- Redirect to 0x100 while a request to 0x8 is outstanding (latency 3) -> the 0x8 response is dropped; the next imem_req is to 0x100; if_valid=0 until the 0x100 data arrives.
- redirect_pc=0x102 -> no imem_req; fault entry pc=0x102, if_fault=1, if_instr=0x00000013; FAULT until redirect to 0x200, which fetches normally.
- Sequential fetch reaching PC=0xFFC and then 0x1000 with IMEM_WORDS=1024 -> 0xFFC fetched; 0x1000 produces a fault entry with no imem_req.
- imem_err=1 on the response for 0x20 -> fault entry pc=0x20; req_pc stays 0x20. Separately, rst_n=0 mid-request -> all outputs zero immediately and the first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state
// encoding, the NOP used as fault-marker payload, the default address
// width and the instruction-memory address check.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    // addi x0, x0, 0 -- carried in fault entries so decode sees a harmless word
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // A PC is fetchable when it is word aligned and its word index lies
    // inside the instruction memory. Callers zero-extend the PC to 64 bits.
    function automatic logic addr_valid(input logic [63:0] pc,
                                        input logic [63:0] words);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[63:2]} < words);
    endfunction

endpackage

// File: rtl/fetch_out_slot.sv
// Single-entry output register between fetch and the IF/ID pipeline
// register. Holds {pc, instr, fault} under a valid/ready handshake; the
// payload is frozen while the entry waits, and a flush empties the slot
// regardless of the consumer.
module fetch_out_slot
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_wr,
    input  logic [XLEN-1:0] i_wr_pc,
    input  logic [31:0]     i_wr_instr,
    input  logic            i_wr_fault,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instr,
    output logic            o_fault
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_fault;

    // Slot occupancy and payload: flush beats write, write beats retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_fault <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_pc    <= i_wr_pc;
            r_instr <= i_wr_instr;
            r_fault <= i_wr_fault;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_fault = r_fault;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer. Owns the fetch PC, keeps at most one
// instruction-memory request in flight, checks each PC before issue and
// hands fetched words (or fault markers) to IF/ID via fetch_out_slot.
// Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt/perf_stall_cnt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     IMEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_err,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_req_pc;
    logic            r_outstanding;
    logic            r_discard;

    logic            w_pc_ok;
    logic            w_issue_ok;
    logic            w_issue_req;
    logic            w_issue_fault;
    logic            w_resp;
    logic            w_slot_wr;
    logic [31:0]     w_slot_instr;
    logic            w_slot_fault;

    assign w_pc_ok = addr_valid(64'(r_req_pc), 64'(IMEM_WORDS));

    // One credit spans the in-flight request and the output slot, so a new
    // request needs no request outstanding and a slot that is empty or
    // retiring this cycle.
    assign w_issue_ok    = (r_state == ST_RUN) && fetch_en && !redirect_valid
                         && !r_outstanding && (!if_valid || if_ready);
    assign w_issue_req   = w_issue_ok && w_pc_ok;
    assign w_issue_fault = w_issue_ok && !w_pc_ok;

    // A response is only accepted for a live request; redirect drops it.
    assign w_resp = imem_rvalid && r_outstanding && !r_discard && !redirect_valid;

    assign w_slot_wr    = w_issue_fault || w_resp;
    assign w_slot_fault = w_issue_fault || imem_err;
    assign w_slot_instr = w_slot_fault ? NOP_INSTR : imem_rdata;

    assign imem_req  = w_issue_req;
    assign imem_addr = r_req_pc;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: redirect always restarts fetch; faults park it.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = ST_RUN;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (fetch_en) w_state_nxt = ST_RUN;
                ST_RUN:   if (w_issue_fault || (w_resp && imem_err)) w_state_nxt = ST_FAULT;
                ST_FAULT: w_state_nxt = ST_FAULT;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Fetch PC and request credit. A redirect without a same-cycle response
    // leaves the old request in flight and marks its response for discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pc      <= RESET_PC;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else if (redirect_valid) begin
            r_req_pc <= redirect_pc;
            if (r_outstanding) begin
                if (imem_rvalid) begin
                    r_outstanding <= 1'b0;
                    r_discard     <= 1'b0;
                end else begin
                    r_discard <= 1'b1;
                end
            end
        end else if (imem_rvalid && r_outstanding) begin
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            if (!r_discard && !imem_err) begin
                r_req_pc <= r_req_pc + PC_STEP;
            end
        end else if (w_issue_req) begin
            r_outstanding <= 1'b1;
        end
    end

    fetch_out_slot #(
        .XLEN (XLEN)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (redirect_valid),
        .i_wr       (w_slot_wr),
        .i_wr_pc    (r_req_pc),
        .i_wr_instr (w_slot_instr),
        .i_wr_fault (w_slot_fault),
        .i_ready    (if_ready),
        .o_valid    (if_valid),
        .o_pc       (if_pc),
        .o_instr    (if_instr),
        .o_fault    (if_fault)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    // Retired-instruction and back-pressure counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (if_valid && if_ready && !if_fault) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (if_valid && !if_ready)             r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle table for steady fetch and
// back-pressure, then hand sequences for redirect, faults, range end,
// bus error and asynchronous reset. Memory is a fixed-latency responder.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    int unsigned lat      = 1;
    logic [63:0] err_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_busy;
    logic [63:0] m_addr;
    int unsigned m_cnt;
    logic        saw_valid;
    logic        saw_req;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .XLEN       (64),
        .RESET_PC   (64'h0),
        .IMEM_WORDS (1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_fault       (if_fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] dat(input logic [63:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Instruction memory: responds exactly 'lat' cycles after the request cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy      <= 1'b0;
            m_addr      <= '0;
            m_cnt       <= 0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            imem_err    <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            imem_err    <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= dat(m_addr);
                    imem_err    <= (m_addr == err_addr);
                    m_busy      <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem_req) begin
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= dat(imem_addr);
                    imem_err    <= (imem_addr == err_addr);
                end else begin
                    m_busy <= 1'b1;
                    m_addr <= imem_addr;
                    m_cnt  <= lat - 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        drive_step();
        redirect_valid = 1'b0;
    endtask

    // Wait (bounded) for a request; records whether an entry appeared meanwhile.
    task automatic wait_req(input logic [63:0] a, input string nm);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!imem_req && n < 40) begin
            if (if_valid) saw_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        check({nm, "_req_seen"}, 64'(imem_req), 64'd1);
        if (imem_req) check({nm, "_addr"}, imem_addr, a);
    endtask

    // Wait (bounded) for an output entry and check its payload.
    task automatic wait_valid(input logic [63:0] pc, input logic [31:0] ins,
                              input logic flt, input string nm);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!if_valid && n < 40) begin
            if (imem_req) saw_req = 1'b1;
            @(negedge clk);
            n++;
        end
        check({nm, "_valid_seen"}, 64'(if_valid), 64'd1);
        if (if_valid) begin
            check({nm, "_pc"}, if_pc, pc);
            check({nm, "_instr"}, 64'(if_instr), 64'(ins));
            check({nm, "_fault"}, 64'(if_fault), 64'(flt));
        end
    endtask

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        req;
        logic [63:0] addr;
        logic        vld;
        logic [63:0] pc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        lat            = 1;
        saw_valid      = 1'b0;
        saw_req        = 1'b0;
        @(negedge clk);
        check("rst_req",   64'(imem_req), 64'd0);
        check("rst_addr",  imem_addr,     64'h0);
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_pc",    if_pc,         64'h0);
        check("rst_instr", 64'(if_instr), 64'h0);
        check("rst_fault", 64'(if_fault), 64'd0);

        // ---- steady fetch, latency 1, then 5 cycles of back-pressure on pc 0x4 ----
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 64'h0, 1'b0, 64'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 64'h4, 1'b1, 64'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h4};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h4};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h4};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 64'h4};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 64'h8, 1'b1, 64'h4};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 64'hC, 1'b1, 64'h8};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0};

        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            fetch_en = tbl[i].fe;
            if_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl%0d_req", i), 64'(imem_req), 64'(tbl[i].req));
            if (tbl[i].req) check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            check($sformatf("tbl%0d_valid", i), 64'(if_valid), 64'(tbl[i].vld));
            if (tbl[i].vld) begin
                check($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
                check($sformatf("tbl%0d_instr", i), 64'(if_instr), 64'(dat(tbl[i].pc)));
                check($sformatf("tbl%0d_fault", i), 64'(if_fault), 64'd0);
            end
            drive_step();
        end

        // ---- redirect to 0x100 while 0x8 is outstanding, latency 3 ----
        lat = 3;
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        wait_req(64'h0, "rd0");
        wait_req(64'h4, "rd4");
        wait_req(64'h8, "rd8");
        drive_step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        @(negedge clk);
        check("rdr_noreq", 64'(imem_req), 64'd0);
        drive_step();
        redirect_valid = 1'b0;
        saw_valid = 1'b0;
        wait_req(64'h100, "rdr");
        check("rdr_no_entry_before", 64'(saw_valid), 64'd0);
        wait_valid(64'h100, dat(64'h100), 1'b0, "rdr_ent");

        // ---- redirect to misaligned 0x102: fault, then recover at 0x200 ----
        lat = 1;
        do_reset();
        if_ready = 1'b1;
        redirect_to(64'h102);
        fetch_en = 1'b1;
        @(negedge clk);
        check("mis_noreq0", 64'(imem_req), 64'd0);
        drive_step();
        @(negedge clk);
        check("mis_valid", 64'(if_valid), 64'd1);
        check("mis_fault", 64'(if_fault), 64'd1);
        check("mis_pc",    if_pc,         64'h102);
        check("mis_instr", 64'(if_instr), 64'(NOP));
        check("mis_noreq1", 64'(imem_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive_step();
            @(negedge clk);
            check($sformatf("mis_park%0d_req", i), 64'(imem_req), 64'd0);
            check($sformatf("mis_park%0d_valid", i), 64'(if_valid), 64'd0);
        end
        drive_step();
        redirect_to(64'h200);
        wait_req(64'h200, "rec");
        wait_valid(64'h200, dat(64'h200), 1'b0, "rec_ent");

        // ---- end of memory: 0xFFC fetched, 0x1000 faults without a request ----
        do_reset();
        if_ready = 1'b1;
        fetch_en = 1'b1;
        redirect_to(64'hFF8);
        wait_req(64'hFF8, "end0");
        wait_req(64'hFFC, "end1");
        wait_valid(64'hFFC, dat(64'hFFC), 1'b0, "end1_ent");
        check("end_noreq", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("end_flt_valid", 64'(if_valid), 64'd1);
        check("end_flt_fault", 64'(if_fault), 64'd1);
        check("end_flt_pc",    if_pc,         64'h1000);
        check("end_flt_instr", 64'(if_instr), 64'(NOP));
        check("end_flt_noreq", 64'(imem_req), 64'd0);

        // ---- bus error on 0x20 ----
        do_reset();
        err_addr = 64'h20;
        if_ready = 1'b1;
        fetch_en = 1'b1;
        redirect_to(64'h1C);
        wait_req(64'h1C, "err0");
        wait_req(64'h20, "err1");
        wait_valid(64'h20, NOP, 1'b1, "err_ent");
        for (int i = 0; i < 3; i++) begin
            drive_step();
            @(negedge clk);
            check($sformatf("err_hold%0d_pc", i), imem_addr, 64'h20);
            check($sformatf("err_hold%0d_req", i), 64'(imem_req), 64'd0);
        end
        err_addr = 64'hFFFF_FFFF_FFFF_FFFF;

        // ---- asynchronous reset with a held entry ----
        do_reset();
        if_ready = 1'b0;
        fetch_en = 1'b1;
        redirect_to(64'h40);
        wait_valid(64'h40, dat(64'h40), 1'b0, "ar_ent");
        #2 rst_n = 1'b0;
        #1;
        check("ar_req",   64'(imem_req), 64'd0);
        check("ar_addr",  imem_addr,     64'h0);
        check("ar_valid", 64'(if_valid), 64'd0);
        check("ar_pc",    if_pc,         64'h0);
        check("ar_instr", 64'(if_instr), 64'h0);
        check("ar_fault", 64'(if_fault), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        if_ready = 1'b1;
        wait_req(64'h0, "ar_first");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
